// File: rtl/vga_pkg.sv
// Shared definitions for the VGA box path: screen geometry, coordinate type,
// drawer state encoding and a clamp helper.
package vga_pkg;
    localparam int CW       = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} box_state_t;

    // Saturate a coordinate to the last visible pixel on its axis.
    function automatic coord_t clamp(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/box_drawer_if.sv
// Request/pixel bundle between the box requester and box_drawer.
interface box_drawer_if;
    import vga_pkg::*;

    logic   start;
    coord_t x0, y0, x1, y1;
    logic   fill;
    logic   color;
    coord_t xBox, yBox;
    logic   boxPixelColor;
    logic   pixel_valid;
    logic   boxStart;
    logic   boxEnd;
    logic   busy;

    modport master (
        output start, x0, y0, x1, y1, fill, color,
        input  xBox, yBox, boxPixelColor, pixel_valid, boxStart, boxEnd, busy
    );

    modport slave (
        input  start, x0, y0, x1, y1, fill, color,
        output xBox, yBox, boxPixelColor, pixel_valid, boxStart, boxEnd, busy
    );
endinterface

// File: rtl/box_corner_norm.sv
// Clamps both corners to the screen and orders them into min/max bounds.
module box_corner_norm
    import vga_pkg::*;
(
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t xmin,
    output coord_t xmax,
    output coord_t ymin,
    output coord_t ymax
);
    coord_t cx0, cy0, cx1, cy1;

    assign cx0 = clamp(x0, coord_t'(SCREEN_W - 1));
    assign cx1 = clamp(x1, coord_t'(SCREEN_W - 1));
    assign cy0 = clamp(y0, coord_t'(SCREEN_H - 1));
    assign cy1 = clamp(y1, coord_t'(SCREEN_H - 1));

    assign xmin = (cx0 < cx1) ? cx0 : cx1;
    assign xmax = (cx0 < cx1) ? cx1 : cx0;
    assign ymin = (cy0 < cy1) ? cy0 : cy1;
    assign ymax = (cy0 < cy1) ? cy1 : cy0;
endmodule

// File: rtl/box_drawer.sv
// Rasterises one axis-aligned box (filled or outline) into a pixel stream,
// one pixel per clock, framed by boxStart / boxEnd pulses.
module box_drawer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    box_drawer_if.slave bus
);
    box_state_t state;
    coord_t     cap_x0, cap_y0, cap_x1, cap_y1;
    logic       cap_fill, cap_color;
    coord_t     xmin_r, xmax_r, ymin_r, ymax_r;
    coord_t     x_r, y_r;
    logic       color_r, pix_valid, box_start, box_end, busy_r;
    coord_t     n_xmin, n_xmax, n_ymin, n_ymax;
    logic       last_pix, interior;

    box_corner_norm u_norm (
        .x0(cap_x0), .y0(cap_y0), .x1(cap_x1), .y1(cap_y1),
        .xmin(n_xmin), .xmax(n_xmax), .ymin(n_ymin), .ymax(n_ymax)
    );

    // Outline rows strictly between the top and bottom edges jump from the
    // left edge straight to the right edge.
    assign last_pix = (x_r == xmax_r) && (y_r == ymax_r);
    assign interior = !cap_fill && (y_r != ymin_r) && (y_r != ymax_r);

    // FSM, corner capture and raster walk; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cap_x0    <= '0;
            cap_y0    <= '0;
            cap_x1    <= '0;
            cap_y1    <= '0;
            cap_fill  <= 1'b0;
            cap_color <= 1'b0;
            xmin_r    <= '0;
            xmax_r    <= '0;
            ymin_r    <= '0;
            ymax_r    <= '0;
            x_r       <= '0;
            y_r       <= '0;
            color_r   <= 1'b0;
            pix_valid <= 1'b0;
            box_start <= 1'b0;
            box_end   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cap_x0    <= bus.x0;
                        cap_y0    <= bus.y0;
                        cap_x1    <= bus.x1;
                        cap_y1    <= bus.y1;
                        cap_fill  <= bus.fill;
                        cap_color <= bus.color;
                        box_start <= 1'b1;
                        busy_r    <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    xmin_r    <= n_xmin;
                    xmax_r    <= n_xmax;
                    ymin_r    <= n_ymin;
                    ymax_r    <= n_ymax;
                    x_r       <= n_xmin;
                    y_r       <= n_ymin;
                    color_r   <= cap_color;
                    pix_valid <= 1'b1;
                    box_start <= 1'b0;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (last_pix) begin
                        pix_valid <= 1'b0;
                        box_end   <= 1'b1;
                        state     <= DONE;
                    end else if (x_r == xmax_r) begin
                        x_r <= xmin_r;
                        y_r <= y_r + 1'b1;
                    end else if (interior && (x_r == xmin_r)) begin
                        x_r <= xmax_r;
                    end else begin
                        x_r <= x_r + 1'b1;
                    end
                end
                DONE: begin
                    box_end <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.xBox          = x_r;
    assign bus.yBox          = y_r;
    assign bus.boxPixelColor = color_r;
    assign bus.pixel_valid   = pix_valid;
    assign bus.boxStart      = box_start;
    assign bus.boxEnd        = box_end;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_box_drawer.sv
// Self-checking bench for box_drawer: a pixel-list model builds the expected
// per-cycle trace, and one negedge process compares the DUT against it.
module tb_box_drawer;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    box_drawer_if bus();
    box_drawer dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit chk_xy;
        bit pv, bs, be, busy, col;
        int x, y;
    } rec_t;
    typedef struct { int x, y; } pix_t;

    rec_t q[$];
    pix_t mp[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Pixel list of a box straight from the geometric rule: clamp, order,
    // walk the bounding box and keep pixels on an edge (or all when filled).
    function automatic void gen(input int x0, y0, x1, y1, input bit fill);
        int cx0, cy0, cx1, cy1, xa, xb, ya, yb;
        cx0 = (x0 > SCREEN_W - 1) ? SCREEN_W - 1 : x0;
        cx1 = (x1 > SCREEN_W - 1) ? SCREEN_W - 1 : x1;
        cy0 = (y0 > SCREEN_H - 1) ? SCREEN_H - 1 : y0;
        cy1 = (y1 > SCREEN_H - 1) ? SCREEN_H - 1 : y1;
        xa = (cx0 < cx1) ? cx0 : cx1;  xb = (cx0 < cx1) ? cx1 : cx0;
        ya = (cy0 < cy1) ? cy0 : cy1;  yb = (cy0 < cy1) ? cy1 : cy0;
        mp.delete();
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                if (fill || y == ya || y == yb || x == xa || x == xb)
                    mp.push_back('{x, y});
    endfunction

    // Expected trace starting with the cycle in which start is sampled.
    function automatic int push_box(input int x0, y0, x1, y1, input bit fill, input bit col);
        rec_t r;
        gen(x0, y0, x1, y1, fill);
        r = '{default: 0};
        q.push_back(r);
        r.bs = 1; r.busy = 1;
        q.push_back(r);
        foreach (mp[i]) begin
            r = '{default: 0};
            r.chk_xy = 1; r.pv = 1; r.busy = 1; r.col = col;
            r.x = mp[i].x; r.y = mp[i].y;
            q.push_back(r);
        end
        r = '{default: 0};
        r.chk_xy = 1; r.be = 1; r.busy = 1;
        r.x = mp[mp.size()-1].x; r.y = mp[mp.size()-1].y;
        q.push_back(r);
        return mp.size() + 3;
    endfunction

    // The single per-cycle comparison against the expected trace.
    always @(negedge clk) begin : cmp
        rec_t r;
        if (reset) begin
            if (q.size() > 0) r = q.pop_front();
            else r = '{default: 0};
            chk("pixel_valid", int'(bus.pixel_valid), int'(r.pv));
            chk("boxStart", int'(bus.boxStart), int'(r.bs));
            chk("boxEnd", int'(bus.boxEnd), int'(r.be));
            chk("busy", int'(bus.busy), int'(r.busy));
            if (r.chk_xy) begin
                chk("xBox", int'(bus.xBox), r.x);
                chk("yBox", int'(bus.yBox), r.y);
            end
            if (r.pv) chk("boxPixelColor", int'(bus.boxPixelColor), int'(r.col));
        end
    end

    task automatic set_in(input int x0, y0, x1, y1, input bit fill, input bit col);
        bus.x0 = coord_t'(x0); bus.y0 = coord_t'(y0);
        bus.x1 = coord_t'(x1); bus.y1 = coord_t'(y1);
        bus.fill = fill; bus.color = col;
    endtask

    task automatic drain();
        int cnt = 0;
        while (q.size() > 0 && cnt < 5000) begin
            @(posedge clk);
            cnt++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run_box(input int x0, y0, x1, y1, input bit fill, input bit col, input bit poke);
        int n;
        @(posedge clk); #1;
        set_in(x0, y0, x1, y1, fill, col);
        bus.start = 1'b1;
        n = push_box(x0, y0, x1, y1, fill, col);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (poke && n >= 6) begin
            // Re-request with different corners while the box is in DRAW.
            @(posedge clk); #1;
            bus.start = 1'b1;
            set_in($urandom_range(0, 2047), $urandom_range(0, 2047),
                   $urandom_range(0, 2047), $urandom_range(0, 2047),
                   1'($urandom), 1'($urandom));
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        drain();
    endtask

    int ex_f[6] = '{10, 11, 12, 10, 11, 12};
    int ey_f[6] = '{20, 20, 20, 21, 21, 21};
    int ex_o[10] = '{5, 6, 7, 5, 7, 5, 7, 5, 6, 7};
    int ey_o[10] = '{5, 5, 5, 6, 6, 7, 7, 8, 8, 8};

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        bus.start = 1'b0;
        set_in(0, 0, 0, 0, 1'b0, 1'b0);

        // Reset values.
        #2;
        chk("rst_xBox", int'(bus.xBox), 0);
        chk("rst_yBox", int'(bus.yBox), 0);
        chk("rst_color", int'(bus.boxPixelColor), 0);
        chk("rst_valid", int'(bus.pixel_valid), 0);
        chk("rst_boxStart", int'(bus.boxStart), 0);
        chk("rst_boxEnd", int'(bus.boxEnd), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Hand-derived pixel lists that pin the model.
        gen(10, 20, 12, 21, 1'b1);
        chk("model_fill_count", mp.size(), 6);
        foreach (ex_f[i]) if (i < mp.size()) begin
            chk("model_fill_x", mp[i].x, ex_f[i]);
            chk("model_fill_y", mp[i].y, ey_f[i]);
        end
        gen(5, 5, 7, 8, 1'b0);
        chk("model_outline_count", mp.size(), 10);
        foreach (ex_o[i]) if (i < mp.size()) begin
            chk("model_outline_x", mp[i].x, ex_o[i]);
            chk("model_outline_y", mp[i].y, ey_o[i]);
        end
        gen(700, 500, 637, 478, 1'b1);
        chk("model_clamp_count", mp.size(), 6);
        chk("model_clamp_first_x", mp[0].x, 637);
        chk("model_clamp_last_y", mp[5].y, 479);

        // Directed boxes.
        run_box(10, 20, 12, 21, 1'b1, 1'b1, 1'b0);
        run_box(5, 5, 7, 8, 1'b0, 1'b1, 1'b0);
        run_box(700, 500, 637, 478, 1'b1, 1'b0, 1'b0);
        run_box(3, 4, 3, 4, 1'b0, 1'b1, 1'b0);
        run_box(20, 30, 20, 35, 1'b0, 1'b1, 1'b1);
        run_box(40, 40, 45, 41, 1'b0, 1'b0, 1'b1);

        // Randomised boxes, some partly or fully off screen.
        for (int it = 0; it < 30; it++) begin
            int ax, ay, bx, by;
            if ($urandom_range(0, 3) == 0) begin
                ax = 634 + $urandom_range(0, 1400);
                ay = 474 + $urandom_range(0, 1500);
            end else begin
                ax = $urandom_range(0, 630);
                ay = $urandom_range(0, 470);
            end
            bx = ax + $urandom_range(0, 7);
            by = ay + $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) run_box(bx, by, ax, ay, 1'($urandom), 1'($urandom), 1'($urandom));
            else run_box(ax, ay, bx, by, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // start held high through DONE retriggers the same box.
        @(posedge clk); #1;
        set_in(100, 200, 102, 203, 1'b0, 1'b1);
        bus.start = 1'b1;
        n = push_box(100, 200, 102, 203, 1'b0, 1'b1);
        n = push_box(100, 200, 102, 203, 1'b0, 1'b1);
        cnt = 0;
        while (q.size() > n - 1 && cnt < 1000) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        bus.start = 1'b0;
        drain();

        // Reset in the middle of a 10x10 filled box.
        @(posedge clk); #1;
        set_in(0, 0, 9, 9, 1'b1, 1'b1);
        bus.start = 1'b1;
        n = push_box(0, 0, 9, 9, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        while (q.size() > n - 22 && cnt < 1000) begin
            @(posedge clk);
            cnt++;
        end
        #2;
        chk("pre_abort_busy", int'(bus.busy), 1);
        reset = 1'b0;
        q.delete();
        #1;
        chk("abort_xBox", int'(bus.xBox), 0);
        chk("abort_yBox", int'(bus.yBox), 0);
        chk("abort_valid", int'(bus.pixel_valid), 0);
        chk("abort_boxEnd", int'(bus.boxEnd), 0);
        chk("abort_busy", int'(bus.busy), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", int'(bus.busy), 0);
        chk("post_reset_boxEnd", int'(bus.boxEnd), 0);
        run_box(0, 0, 9, 9, 1'b1, 1'b1, 1'b0);
        run_box(8, 2, 1, 6, 1'b0, 1'b0, 1'b0);

        @(posedge clk); @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
